// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder: FSM state encoding,
// default geometry/latency and the data value returned on write or error
// responses.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int          DEFAULT_DEPTH       = 1024;
    localparam int          DEFAULT_WAIT_CYCLES = 2;
    localparam logic [31:0] ERR_DATA            = 32'h0;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with per-byte write enables and a registered
// read port. The read register samples only when en is high, so it holds
// its value between accesses; clr forces the sampled value to ERR_DATA.
// Only the read register is reset, never the storage.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [3:0]                 we,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [31:0]                wdata,
    input  logic                       clr,
    output logic [31:0]                rdata
);

    logic [31:0] mem [DEPTH];

    // Byte-lane writes; lanes with a clear enable keep their old contents.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read register: updated only on an access, otherwise holds its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= ERR_DATA;
        end else if (en) begin
            rdata <= clr ? ERR_DATA : mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one access at a time from the core memory
// stage, waits WAIT_CYCLES cycles, then produces a one-cycle response.
// The array access (write commit and read sample) happens on the edge that
// enters RESP. Optional macro DMEM_RANGE_CHECK_EN flags accesses above the
// array with err, suppresses their writes and returns zero data; without it
// the upper address bits are ignored and accesses alias.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        request,
    input  logic        we_re,
    input  logic [3:0]  mask,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        ready,
    output logic        valid,
    output logic [31:0] load_data,
    output logic        err
);

    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state;
    logic [3:0]  count;

    logic        req_we;
    logic [3:0]  req_mask;
    logic [31:0] req_addr;
    logic [31:0] req_data;

    logic        accept;
    logic        enter_resp;
    logic        acc_we;
    logic [3:0]  acc_mask;
    logic [31:0] acc_addr;
    logic [31:0] acc_data;
    logic        out_of_range;
    logic [3:0]  ram_we;
    logic        ram_clr;
    logic        unused_addr_bits;

    assign accept = (state == IDLE) && request;

    // The array access coincides with entry into RESP. With no wait states
    // that edge is the acceptance edge itself, so the live inputs are used;
    // otherwise the captured request fields are.
    always_comb begin
        acc_we   = req_we;
        acc_mask = req_mask;
        acc_addr = req_addr;
        acc_data = req_data;
        if (state == IDLE) begin
            acc_we   = we_re;
            acc_mask = mask;
            acc_addr = address;
            acc_data = store_data;
        end
    end

    assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                        ((state == WAIT) && (count == 4'd1));

`ifdef DMEM_RANGE_CHECK_EN
    assign out_of_range = |acc_addr[31:AW+2];
`else
    assign out_of_range = 1'b0;
`endif

    // Byte offset bits never select anything; upper bits only matter with range checking.
    assign unused_addr_bits = ^{acc_addr[31:AW+2], acc_addr[1:0]};

    assign ram_we  = (enter_resp && acc_we && !out_of_range) ? acc_mask : 4'b0000;
    assign ram_clr = acc_we || out_of_range;

    // Control FSM: sequences IDLE -> WAIT -> RESP -> IDLE with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= 4'd0;
            ready <= 1'b1;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                            valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            count <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= RESP;
                        valid <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    count <= 4'd0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    // Capture the request fields at acceptance; they are pure data, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_we   <= we_re;
            req_mask <= mask;
            req_addr <= address;
            req_data <= store_data;
        end
    end

`ifdef DMEM_RANGE_CHECK_EN
    // Error flag accompanies the response strobe for out-of-range accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= enter_resp && out_of_range;
        end
    end
`else
    assign err = 1'b0;
`endif

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (enter_resp),
        .we    (ram_we),
        .addr  (acc_addr[AW+1:2]),
        .wdata (acc_data),
        .clr   (ram_clr),
        .rdata (load_data)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a WAIT_CYCLES=2 instance for
// the main scenarios and a WAIT_CYCLES=0 instance for the zero-wait case.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        request = 1'b0, we_re = 1'b0;
    logic [3:0]  mask = 4'h0;
    logic [31:0] address = 32'h0, store_data = 32'h0;
    logic        ready, valid, err;
    logic [31:0] load_data;

    logic        z_request = 1'b0, z_we_re = 1'b0;
    logic [3:0]  z_mask = 4'h0;
    logic [31:0] z_address = 32'h0, z_store_data = 32'h0;
    logic        z_ready, z_valid, z_err;
    logic [31:0] z_load_data;

    int total = 0;
    int bad   = 0;
    int vcount = 0;
    int z_vcount = 0;
    logic [31:0] last_data;

    logic [32:0] sb_q[$];
    logic [32:0] z_q[$];
    logic [31:0] mdl [0:1023];
    logic [31:0] z_mdl [0:1023];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .request(request), .we_re(we_re), .mask(mask),
        .address(address), .store_data(store_data), .ready(ready),
        .valid(valid), .load_data(load_data), .err(err)
    );

    data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .request(z_request), .we_re(z_we_re), .mask(z_mask),
        .address(z_address), .store_data(z_store_data), .ready(z_ready),
        .valid(z_valid), .load_data(z_load_data), .err(z_err)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    // Scoreboard for the WAIT_CYCLES=2 instance.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            logic [32:0] e;
            vcount++;
            total++;
            last_data = load_data;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got data=%h err=%b, required no response", load_data, err);
            end else begin
                e = sb_q.pop_front();
                if ({err, load_data} !== e) begin
                    bad++;
                    $display("FAIL response: got err=%b data=%h, required err=%b data=%h",
                             err, load_data, e[32], e[31:0]);
                end
            end
        end
    end

    // Scoreboard for the WAIT_CYCLES=0 instance.
    always @(negedge clk) begin
        if (z_valid === 1'b1) begin
            logic [32:0] e;
            z_vcount++;
            total++;
            if (z_q.size() == 0) begin
                bad++;
                $display("FAIL z_unexpected_valid: got data=%h, required no response", z_load_data);
            end else begin
                e = z_q.pop_front();
                if ({z_err, z_load_data} !== e) begin
                    bad++;
                    $display("FAIL z_response: got err=%b data=%h, required err=%b data=%h",
                             z_err, z_load_data, e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [32:0] expect_access(input logic w, input logic [3:0] m,
                                                  input logic [31:0] a, input logic [31:0] d);
        logic oor;
        int   idx;
        idx = int'(a[11:2]);
`ifdef DMEM_RANGE_CHECK_EN
        oor = (a[31:12] != 20'h0);
`else
        oor = 1'b0;
`endif
        if (oor) return {1'b1, 32'h0};
        if (w) begin
            mdl[idx] = merge(mdl[idx], d, m);
            return {1'b0, 32'h0};
        end
        return {1'b0, mdl[idx]};
    endfunction

    task automatic do_access(input logic w, input logic [3:0] m, input logic [31:0] a,
                             input logic [31:0] d);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_wait: ready=%b, required 1", ready);
        end
        sb_q.push_back(expect_access(w, m, a, d));
        request = 1'b1; we_re = w; mask = m; address = a; store_data = d;
        @(negedge clk);
        request = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 30) begin @(negedge clk); n++; end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL response_timeout: pending=%0d, required 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic z_access(input logic w, input logic [3:0] m, input logic [31:0] a,
                            input logic [31:0] d);
        int n;
        int idx;
        idx = int'(a[11:2]);
        if (w) begin
            z_mdl[idx] = merge(z_mdl[idx], d, m);
            z_q.push_back({1'b0, 32'h0});
        end else begin
            z_q.push_back({1'b0, z_mdl[idx]});
        end
        z_request = 1'b1; z_we_re = w; z_mask = m; z_address = a; z_store_data = d;
        @(negedge clk);
        z_request = 1'b0;
        n = 0;
        while (z_q.size() != 0 && n < 10) begin @(negedge clk); n++; end
        total++;
        if (z_q.size() != 0) begin
            bad++;
            $display("FAIL z_response_timeout: pending=%0d, required 0", z_q.size());
            z_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        request = 1'b1;
        @(negedge clk);
        total++;
        if ({ready, valid, err, load_data} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b valid=%b err=%b data=%h, required 1 0 0 0",
                     ready, valid, err, load_data);
        end
        request = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_timing;
        do_access(1'b1, 4'hF, 32'h0, 32'h12345678);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL timing_ready_T: ready=%b, required 1", ready);
        end
        sb_q.push_back(expect_access(1'b0, 4'h0, 32'h0, 32'h0));
        request = 1'b1; we_re = 1'b0; mask = 4'h0; address = 32'h0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            request = 1'b0;
            total++;
            if (ready !== (k == 4) || valid !== (k == 3)) begin
                bad++;
                $display("FAIL timing_T+%0d: ready=%b valid=%b, required %b %b",
                         k, ready, valid, (k == 4), (k == 3));
            end
        end
        total++;
        if (last_data !== 32'h12345678) begin
            bad++;
            $display("FAIL reset_keeps_array: got %h, required 12345678", last_data);
        end
    endtask

    task automatic test_masked_write;
        do_access(1'b1, 4'hF, 32'h10, 32'hAABBCCDD);
        do_access(1'b1, 4'b0010, 32'h10, 32'h00001100);
        do_access(1'b0, 4'hF, 32'h10, 32'h0);
        total++;
        if (last_data !== 32'hAABB11DD) begin
            bad++;
            $display("FAIL masked_write: got %h, required AABB11DD", last_data);
        end
        do_access(1'b1, 4'b0000, 32'h10, 32'h99999999);
        do_access(1'b0, 4'h0, 32'h13, 32'h0);
        total++;
        if (last_data !== 32'hAABB11DD) begin
            bad++;
            $display("FAIL mask_zero_offset: got %h, required AABB11DD", last_data);
        end
    endtask

    task automatic test_busy_ignore;
        int v0;
        do_access(1'b1, 4'hF, 32'h30, 32'h30303030);
        do_access(1'b1, 4'hF, 32'h34, 32'h34343434);
        v0 = vcount;
        sb_q.push_back(expect_access(1'b0, 4'h0, 32'h30, 32'h0));
        request = 1'b1; we_re = 1'b0; address = 32'h30;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) begin
                address = 32'h34;
                sb_q.push_back(expect_access(1'b0, 4'h0, 32'h34, 32'h0));
            end
        end
        total++;
        if (ready !== 1'b1 || vcount - v0 != 1) begin
            bad++;
            $display("FAIL busy_T+4: ready=%b valids=%0d, required 1 1", ready, vcount - v0);
        end
        @(negedge clk);
        request = 1'b0;
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL busy_accept_T+4: ready=%b, required 0", ready);
        end
        for (int n = 0; n < 10 && sb_q.size() != 0; n++) @(negedge clk);
        total++;
        if (vcount - v0 != 2) begin
            bad++;
            $display("FAIL busy_valid_count: got %0d, required 2", vcount - v0);
        end
        sb_q.delete();
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        sb_q.push_back(expect_access(1'b1, 4'hF, 32'h40, 32'hCAFEF00D));
        sb_q.push_back(expect_access(1'b0, 4'hF, 32'h40, 32'h0));
        request = 1'b1; we_re = 1'b1; mask = 4'hF; address = 32'h40; store_data = 32'hCAFEF00D;
        @(negedge clk);
        we_re = 1'b0;
        repeat (4) @(negedge clk);
        request = 1'b0;
        for (int n = 0; n < 10 && sb_q.size() != 0; n++) @(negedge clk);
        total++;
        if (last_data !== 32'hCAFEF00D || sb_q.size() != 0) begin
            bad++;
            $display("FAIL read_after_write: got %h pending=%0d, required CAFEF00D 0",
                     last_data, sb_q.size());
        end
        sb_q.delete();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait;
        int v0;
        do_access(1'b1, 4'hF, 32'h20, 32'h0BADF00D);
        request = 1'b1; we_re = 1'b1; mask = 4'hF; address = 32'h20; store_data = 32'hFFFFFFFF;
        @(negedge clk);
        request = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        v0 = vcount;
        repeat (6) @(negedge clk);
        total++;
        if (vcount != v0 || ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_wait: valids=%0d ready=%b, required 0 1", vcount - v0, ready);
        end
        do_access(1'b0, 4'hF, 32'h20, 32'h0);
        total++;
        if (last_data !== 32'h0BADF00D) begin
            bad++;
            $display("FAIL reset_discard_write: got %h, required 0BADF00D", last_data);
        end
    endtask

    task automatic test_range;
        do_access(1'b1, 4'hF, 32'h00001000, 32'h5A5A5A5A);
        do_access(1'b0, 4'hF, 32'h0, 32'h0);
        total++;
`ifdef DMEM_RANGE_CHECK_EN
        if (last_data !== 32'h12345678) begin
            bad++;
            $display("FAIL range_suppress: got %h, required 12345678", last_data);
        end
`else
        if (last_data !== 32'h5A5A5A5A) begin
            bad++;
            $display("FAIL range_alias: got %h, required 5A5A5A5A", last_data);
        end
`endif
    endtask

    task automatic test_zero_wait;
        z_access(1'b1, 4'hF, 32'h4, 32'h11112222);
        z_access(1'b1, 4'hF, 32'h8, 32'h33334444);
        total++;
        if (z_ready !== 1'b1) begin
            bad++;
            $display("FAIL z_ready_T: ready=%b, required 1", z_ready);
        end
        z_q.push_back({1'b0, z_mdl[1]});
        z_q.push_back({1'b0, z_mdl[2]});
        z_request = 1'b1; z_we_re = 1'b0; z_mask = 4'h0; z_address = 32'h4;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            if (k == 1) z_address = 32'h8;
            total++;
            if (z_valid !== (k != 2) || z_ready !== (k == 2)) begin
                bad++;
                $display("FAIL z_timing_T+%0d: valid=%b ready=%b, required %b %b",
                         k, z_valid, z_ready, (k != 2), (k == 2));
            end
        end
        z_request = 1'b0;
        @(negedge clk);
        total++;
        if (z_q.size() != 0) begin
            bad++;
            $display("FAIL z_back_to_back: pending=%0d, required 0", z_q.size());
        end
        z_q.delete();
    endtask

    initial begin
        test_reset();
        test_read_timing();
        test_masked_write();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_wait();
        test_range();
        test_zero_wait();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in the array (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states between acceptance and response (0..15).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-005 SHALL have port request  in  1  access request from the core memory stage.
REQ-006 SHALL have port we_re  in  1  1 = write, 0 = read; sampled with request.
REQ-007 SHALL have port mask  in  4  byte-lane write enables; bit i enables bits [8i+7:8i].
REQ-008 SHALL have port address  in  32  byte address; the word index is address[AW+1:2], where AW = log2(DEPTH).
REQ-009 SHALL have port store_data  in  32  lane-aligned write data.
REQ-010 SHALL have port ready  out  1  high when a request can be accepted.
REQ-011 SHALL have port valid  out  1  one-cycle response strobe.
REQ-012 SHALL have port load_data  out  32  read data, qualified by valid.
REQ-013 SHALL have port err  out  1  access error, qualified by valid.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-015 In IDLE, ready SHALL be 1; in WAIT and RESP, ready SHALL be 0.
REQ-016 SHALL accept a request in cycle T when request=1 and ready=1, registering we_re, mask, address and store_data.
REQ-017 After acceptance, SHALL load an internal counter with WAIT_CYCLES and enter WAIT; with WAIT_CYCLES=0, SHALL enter RESP directly.
REQ-018 In WAIT, SHALL decrement the counter each cycle and enter RESP on the edge where the counter equals 1.
REQ-019 valid SHALL be 1 exactly in cycle T+1+WAIT_CYCLES (the RESP cycle) and 0 in all other cycles.
REQ-020 SHALL return from RESP to IDLE unconditionally; the earliest next acceptance is cycle T+2+WAIT_CYCLES.
REQ-021 SHALL ignore request while ready=0; no queueing and no side effects.
REQ-022 SHALL commit a write on the edge entering RESP, updating only the lanes whose mask bit is 1; with mask=0000, the array SHALL be unchanged.
REQ-023 For a read, load_data SHALL be the full addressed word, registered on the edge entering RESP, ignoring mask.
REQ-024 For a write response, load_data SHALL be 32'h0.
REQ-025 SHALL hold load_data stable outside RESP at its last value.
REQ-026 SHALL ignore address[1:0]; lane selection is carried entirely by mask.
REQ-027 A read in the RESP cycle immediately following a write to the same word SHALL return the written data.

Reset
REQ-028 While rst=1, SHALL force state=IDLE, counter=0, ready=1, valid=0, load_data=0 and err=0.
REQ-029 SHALL discard a pending access when reset is asserted during WAIT; no write is committed.
REQ-030 SHALL NOT reset the array contents.

Configuration
REQ-031 With macro DMEM_RANGE_CHECK_EN defined, an access whose address[31:AW+2] is not all zeros SHALL give err=1 in RESP, suppress the write, and return load_data=0.
REQ-032 Without DMEM_RANGE_CHECK_EN, err SHALL be tied to 0 and address bits above AW+1 SHALL be ignored, so accesses alias.

Structure
REQ-033 Shared package dmem_pkg SHALL hold the FSM state enumeration, the DEPTH and WAIT_CYCLES defaults, and the error-response data constant 32'h0.
REQ-034 The storage SHALL be a sub-module dmem_array: a single-port, byte-write-enable synchronous RAM; the FSM and counter SHALL reside in data_mem_responder.

Verification
REQ-035 Reset then read: rst pulse, then read address 0x0 -> ready=0 for 3 cycles, valid in cycle T+3, ready=1 in cycle T+4.
REQ-036 Masked write: write 0xAABBCCDD with mask 1111 to 0x10, then 0x00001100 with mask 0010 -> read 0x10 returns 0xAABB11DD.
REQ-037 Busy ignore: a second request held high during WAIT -> exactly one valid, and the second request is accepted only in cycle T+4.
REQ-038 Reset mid-WAIT: write 0xFFFFFFFF to 0x20, assert rst in cycle T+1 -> valid never rises and a read of 0x20 returns the old value.
REQ-039 Range check (macro defined, DEPTH=1024): write to 0x00001000 -> err=1 with valid, and a read of 0x0 is unchanged; macro undefined -> err=0 and the write lands at word 0.
REQ-040 WAIT_CYCLES=0: back-to-back reads of 0x4 and 0x8 -> valid in cycles T+1 and T+3, both with correct data.
